// File: rtl/rice_bus_sram_responder_if.sv
// rice_bus_if: request/response data bus between a bus master (core EX stage)
// and a slave such as rice_bus_sram_responder. One request is carried per
// request handshake, one response per response handshake.
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();

    logic                      request_valid;
    logic                      request_ready;
    logic                      request_write;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic                      response_valid;
    logic                      response_ready;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      error;

    modport master (
        output request_valid,
        input  request_ready,
        output request_write,
        output address,
        output write_data,
        output strobe,
        input  response_valid,
        output response_ready,
        input  read_data,
        input  error
    );

    modport slave (
        input  request_valid,
        output request_ready,
        input  request_write,
        input  address,
        input  write_data,
        input  strobe,
        output response_valid,
        input  response_ready,
        output read_data,
        output error
    );

endinterface

// File: rtl/rice_bus_sram_responder.sv
// rice_bus_sram_responder: single-port SRAM behind the rice_bus_if slave side.
// Accepts one request at a time, commits writes with byte strobes in the
// accept cycle and answers after LATENCY wait states (0..15).
// DATA_WIDTH is expected to be 32 or 64; WORDS a power of two (>= 2).
// Optional feature: define RICE_BUS_SRAM_RANGE_CHECK_EN to flag requests
// outside [BASE_ADDRESS, BASE_ADDRESS + WORDS*DATA_WIDTH/8) with error=1
// instead of letting the address wrap modulo the memory size.
module rice_bus_sram_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       WORDS         = 1024,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
    parameter int                       LATENCY       = 1
) (
    input logic       i_clk,
    input logic       i_rst,
    rice_bus_if.slave bus_if
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IDX_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Counter value loaded on accept; WAIT exits when it reaches zero.
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    zero_data_q, zero_data_d;
    logic [3:0]              cnt_q, cnt_d;

    logic                    request_ready;
    logic                    accept;
    logic                    in_range;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IDX_BITS-1:0]     word_idx;
    logic                    offset_unused;
    logic                    mem_we;
    logic                    mem_re;
    logic [LANES-1:0]        lane_we;

    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic [DATA_WIDTH-1:0]   rd_word_q;

    // ready_q already reads 1 while reset is held (IDLE is the reset state),
    // so the port is masked for that cycle; this also keeps reset cycles from
    // ever accepting or writing.
    assign request_ready = ready_q && !i_rst;
    assign accept        = bus_if.request_valid && request_ready;

    // Byte offset into the memory; the bits below lane granularity and above
    // the index are intentionally dropped (modulo WORDS).
    assign offset        = bus_if.address - BASE_ADDRESS;
    assign word_idx      = offset[LANE_BITS +: IDX_BITS];
    assign offset_unused = ^offset;

`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
    localparam logic [ADDRESS_WIDTH:0] MEM_BYTES =
        (ADDRESS_WIDTH + 1)'(longint'(WORDS) * longint'(LANES));

    logic error_q, error_d;

    assign in_range = (bus_if.address >= BASE_ADDRESS) && ({1'b0, offset} < MEM_BYTES);
`else
    assign in_range = 1'b1;
`endif

    assign mem_we = accept && bus_if.request_write && in_range;
    assign mem_re = accept && !bus_if.request_write;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
        assign lane_we[gi] = mem_we && bus_if.strobe[gi];
    end

    // Memory array: byte-lane writes and a registered read, both on accept.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (lane_we[b]) begin
                mem[word_idx][b*8 +: 8] <= bus_if.write_data[b*8 +: 8];
            end
        end
        if (mem_re) begin
            rd_word_q <= mem[word_idx];
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/RESPOND sequencer.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        resp_valid_d = resp_valid_q;
        zero_data_d  = zero_data_q;
        cnt_d        = cnt_q;
`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
        error_d      = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ready_d     = 1'b0;
                    // Writes and rejected requests answer with zero data.
                    zero_data_d = bus_if.request_write || !in_range;
                    cnt_d       = WAIT_LOAD;
`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
                    error_d     = !in_range;
`endif
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d      = ST_RESPOND;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESPOND;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                if (bus_if.response_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    ready_d      = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                ready_d      = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops any pending response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            zero_data_q  <= 1'b1;
            cnt_q        <= 4'd0;
`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            zero_data_q  <= zero_data_d;
            cnt_q        <= cnt_d;
`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
            error_q      <= error_d;
`endif
        end
    end

    assign bus_if.request_ready  = request_ready;
    assign bus_if.response_valid = resp_valid_q;
    assign bus_if.read_data      = zero_data_q ? '0 : rd_word_q;
`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
    assign bus_if.error          = error_q;
`else
    assign bus_if.error          = 1'b0;
`endif

endmodule

// File: tb/tb_rice_bus_sram_responder.sv
// Bench for rice_bus_sram_responder: three instances with LATENCY 0, 1 and 3
// share clock and reset. Directed vectors come from a table; a randomized
// phase is checked against a word-array model of the memory.
module tb_rice_bus_sram_responder;

`ifdef RICE_BUS_SRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [2:0]  rsp_ready;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_strb  [3];
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic [31:0] rsp_rdata [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [3][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
        rice_bus_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.request_valid  = req_valid[gi];
        assign bus.request_write  = req_write[gi];
        assign bus.address        = req_addr[gi];
        assign bus.write_data     = req_wdata[gi];
        assign bus.strobe         = req_strb[gi];
        assign bus.response_ready = rsp_ready[gi];
        assign req_ready[gi]      = bus.request_ready;
        assign rsp_valid[gi]      = bus.response_valid;
        assign rsp_err[gi]        = bus.error;
        assign rsp_rdata[gi]      = bus.read_data;

        rice_bus_sram_responder #(
            .ADDRESS_WIDTH(32),
            .DATA_WIDTH   (32),
            .WORDS        (1024),
            .BASE_ADDRESS (32'h0),
            .LATENCY      (LAT)
        ) dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus_if(bus)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: word array, byte strobes, wrap modulo 1024 words, and
    // out-of-range rejection only when the range check is built.
    task automatic mdl_apply(input int k, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] st,
                             output logic [31:0] rd, output bit err);
        bit oor;
        int idx;
        oor = RC && (addr >= 32'h1000);
        idx = int'((addr / 4) % 1024);
        err = oor;
        rd  = 32'h0;
        if (!oor) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mdl[k][idx][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                rd = mdl[k][idx];
            end
        end
    endtask

    // One full transaction on instance k: accept, latency, optional held
    // response with noise on the request side, handshake, return to idle.
    task automatic do_txn(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int hold, input bit pre,
                          input logic [31:0] exp_rd, input bit exp_err, input string tag);
        int          edges;
        int          w;
        bit          ok;
        logic [31:0] rd0;
        logic        e0;
        w = 0;
        @(negedge clk);
        while (!req_ready[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready_before"}, {31'b0, req_ready[k]}, 32'h1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_strb[k]  = st;
        rsp_ready[k] = pre;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        // Request fields change after accept; they must be ignored.
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = $urandom();
        req_wdata[k] = $urandom();
        req_strb[k]  = 4'hF;
        ok = 1'b1;
        while (!rsp_valid[k] && edges < 40) begin
            if (req_ready[k]) ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(edges - 1), 32'(lat_of(k)));
        if (req_ready[k]) ok = 1'b0;
        rd0 = rsp_rdata[k];
        e0  = rsp_err[k];
        for (int i = 0; i < hold; i++) begin
            req_valid[k] = (i % 2 == 0);
            req_write[k] = 1'b1;
            req_addr[k]  = addr;
            req_wdata[k] = ~wd ^ 32'h0F0F_0F0F;
            req_strb[k]  = 4'hF;
            @(posedge clk);
            @(negedge clk);
            if (!rsp_valid[k] || req_ready[k] || rsp_rdata[k] !== rd0 || rsp_err[k] !== e0)
                ok = 1'b0;
        end
        req_valid[k] = 1'b0;
        chk({tag, " busy_stable"}, {31'b0, ok}, 32'h1);
        chk({tag, " read_data"}, rd0, exp_rd);
        chk({tag, " error"}, {31'b0, e0}, {31'b0, exp_err});
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " idle_after"}, {30'b0, req_ready[k], rsp_valid[k]}, 32'h2);
        rsp_ready[k] = 1'b0;
        $display("txn %s k=%0d wr=%0d addr=%h wd=%h st=%h rd=%h err=%0d lat=%0d",
                 tag, k, wr, addr, wd, st, rd0, e0, edges - 1);
    endtask

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          hold;
        bit          pre;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    initial begin
        logic [31:0] erd;
        bit          eerr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          wr;
        int          k;
        int          hold;

        vt[0]  = '{1, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1, 1'b0, 32'h10,   32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1, 1'b0, 32'h13,   32'h0,        4'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[3]  = '{1, 1'b1, 32'h20,   32'h11223344, 4'hF, 0, 1'b0, 32'h0,        1'b0};
        vt[4]  = '{1, 1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 1'b0, 32'h0,        1'b0};
        vt[5]  = '{1, 1'b0, 32'h20,   32'h0,        4'h0, 5, 1'b0, 32'h11BB33DD, 1'b0};
        vt[6]  = '{1, 1'b0, 32'h20,   32'h0,        4'h0, 0, 1'b0, 32'h11BB33DD, 1'b0};
        vt[7]  = '{0, 1'b1, 32'h44,   32'hA1B2C3D4, 4'hF, 0, 1'b1, 32'h0,        1'b0};
        vt[8]  = '{0, 1'b1, 32'h44,   32'h55667788, 4'hA, 0, 1'b0, 32'h0,        1'b0};
        vt[9]  = '{0, 1'b0, 32'h44,   32'h0,        4'h0, 3, 1'b0, 32'h55B277D4, 1'b0};
        vt[10] = '{0, 1'b0, 32'h46,   32'h0,        4'h0, 0, 1'b1, 32'h55B277D4, 1'b0};
        vt[11] = '{2, 1'b1, 32'h80,   32'h0F0F0F0F, 4'hF, 0, 1'b1, 32'h0,        1'b0};
        vt[12] = '{2, 1'b0, 32'h80,   32'h0,        4'h0, 2, 1'b0, 32'h0F0F0F0F, 1'b0};
        vt[13] = '{1, 1'b1, 32'h0,    32'h01020304, 4'hF, 0, 1'b0, 32'h0,        1'b0};
        vt[14] = '{1, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, 1'b0, 32'h0,        RC};
        vt[15] = '{1, 1'b0, 32'h0,    32'h0,        4'h0, 0, 1'b0,
                   RC ? 32'h01020304 : 32'h5A5A5A5A, 1'b0};
        vt[16] = '{1, 1'b0, 32'h1000, 32'h0,        4'h0, 0, 1'b0,
                   RC ? 32'h0 : 32'h5A5A5A5A, RC};

        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        rsp_ready = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_strb[i]  = '0;
        end

        // Reset: ready masked during reset, then idle outputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready_during", {29'b0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready_after", {29'b0, req_ready}, 32'h7);
        chk("reset resp_valid", {29'b0, rsp_valid}, 32'h0);
        chk("reset error", {29'b0, rsp_err}, 32'h0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset read_data%0d", i), rsp_rdata[i], 32'h0);

        // Directed vectors.
        for (int i = 0; i < NV; i++)
            do_txn(vt[i].k, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].st, vt[i].hold,
                   vt[i].pre, vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));

        // Reset while in WAIT after a write: response dropped, write kept.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'hCAFEF00D;
        req_strb[2]  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("rstwait in_wait", {30'b0, req_ready[2], rsp_valid[2]}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstwait resp_valid", {31'b0, rsp_valid[2]}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rstwait ready", {31'b0, req_ready[2]}, 32'h1);
        do_txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0, "rstwait_read");

        // Randomized phase: seed words 64..79 on each instance, then mix.
        for (int kk = 0; kk < 3; kk++) begin
            for (int idx = 64; idx < 80; idx++) begin
                a = 32'(idx * 4);
                d = $urandom();
                mdl_apply(kk, 1'b1, a, d, 4'hF, erd, eerr);
                do_txn(kk, 1'b1, a, d, 4'hF, 0, 1'b0, erd, eerr, "seed");
            end
        end
        for (int n = 0; n < 60; n++) begin
            k    = int'($urandom_range(0, 2));
            wr   = 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(64, 79) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | 32'h1000;
            d    = $urandom();
            s    = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            mdl_apply(k, wr, a, d, s, erd, eerr);
            do_txn(k, wr, a, d, s, hold, (hold == 0) && ($urandom_range(0, 1) == 1),
                   erd, eerr, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
